// File: rtl/seq_debug_mailbox_pkg.sv
// Shared constants and types for the sequencer debug command mailbox.
package seq_debug_mailbox_pkg;

  // Byte offsets of the mailbox registers from the debug region base.
  localparam int unsigned REQ_CMD_OFS    = 'h8;
  localparam int unsigned CMD_STATUS_OFS = 'hC;
  localparam int unsigned PARAMS_OFS     = 'h10;

  // Command hand-off state; encoding is visible in CMD_STATUS[1:0].
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } mb_state_t;

  // CMD_STATUS field positions.
  localparam int unsigned STAT_STATE_LSB  = 0;
  localparam int unsigned STAT_COUNT_LSB  = 4;
  localparam int unsigned STAT_OVF_BIT    = 8;
  localparam int unsigned STAT_BAD_BIT    = 9;
  localparam int unsigned STAT_RESULT_LSB = 16;

endpackage

// File: rtl/seq_debug_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module seq_debug_cmd_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array: data only, qualified by count so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seq_debug_cmd_mailbox.sv
// Avalon-MM debug command mailbox: host-written commands are queued and
// handed to the sequencer core over valid/ready; the result lands in status.
module seq_debug_cmd_mailbox
  import seq_debug_mailbox_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = 'h00015238,
  parameter int unsigned NUM_PARAMS = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CMD_ID_W   = 8,
  parameter int unsigned CMD_ID_MAX = 'h16,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic                     avl_clk,
  input  logic                     avl_reset_n,
  input  logic [ADDR_W-1:0]        avl_address,
  input  logic                     avl_read,
  input  logic                     avl_write,
  input  logic [31:0]              avl_writedata,
  output logic [31:0]              avl_readdata,
  output logic                     avl_readdatavalid,
  output logic                     avl_waitrequest,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [CMD_ID_W-1:0]      cmd_id,
  output logic [32*NUM_PARAMS-1:0] cmd_params,
  input  logic                     rsp_valid,
  input  logic [15:0]              rsp_result
);

  localparam int unsigned FW = CMD_ID_W + 32*NUM_PARAMS;
  localparam int unsigned CW = $clog2(DEPTH+1);

  mb_state_t                state_q, state_d;
  logic                     done_show_q;
  logic [31:0]              params_q [NUM_PARAMS];
  logic [CMD_ID_W-1:0]      last_id_q;
  logic                     ovf_q;
  logic                     bad_q;
  logic [15:0]              last_result_q;

  logic [ADDR_W-1:0]        ofs;
  logic [ADDR_W-1:0]        pofs;
  logic                     is_req;
  logic                     is_stat;
  logic [NUM_PARAMS-1:0]    par_hit;
  logic [CMD_ID_W-1:0]      wr_id;
  logic                     id_ok;
  logic                     push_req;
  logic                     pop;

  logic [32*NUM_PARAMS-1:0] snap;
  logic [FW-1:0]            fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [3:0]               cnt_sat;
  mb_state_t                rep_state;
  logic [31:0]              stat;
  logic [31:0]              rd_data;

  assign avl_waitrequest = 1'b0;

  assign ofs     = avl_address - ADDR_W'(BASE_ADDR);
  assign pofs    = ofs - ADDR_W'(PARAMS_OFS);
  assign is_req  = (ofs == ADDR_W'(REQ_CMD_OFS));
  assign is_stat = (ofs == ADDR_W'(CMD_STATUS_OFS));
  assign wr_id   = avl_writedata[CMD_ID_W-1:0];
  assign id_ok   = (32'(wr_id) <= 32'(CMD_ID_MAX));
  assign push_req = avl_write && is_req && id_ok;

  // Per-register hit for the parameter bank; misaligned offsets match nothing.
  always_comb begin
    par_hit = '0;
    for (int unsigned i = 0; i < NUM_PARAMS; i++)
      par_hit[i] = (pofs == ADDR_W'(4*i));
  end

  // Flatten the live parameter registers into the queue entry, param 0 in LSBs.
  always_comb begin
    snap = '0;
    for (int unsigned i = 0; i < NUM_PARAMS; i++)
      snap[32*i +: 32] = params_q[i];
  end

  seq_debug_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (avl_clk),
    .rst_n (avl_reset_n),
    .push  (push_req),
    .pop   (pop),
    .wdata ({wr_id, snap}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head is only exposed while offered, so idle outputs read as zero.
  assign cmd_valid  = (state_q == ST_ISSUE);
  assign cmd_id     = cmd_valid ? fifo_rdata[FW-1 -: CMD_ID_W] : '0;
  assign cmd_params = cmd_valid ? fifo_rdata[32*NUM_PARAMS-1:0] : '0;

  // Next-state logic; the pop is the ISSUE handshake.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_ready) begin
        pop     = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY:  if (rsp_valid) state_d = ST_DONE;
      ST_DONE:  state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; DONE keeps being reported through IDLE until next ISSUE.
  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      state_q     <= ST_IDLE;
      done_show_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_DONE)       done_show_q <= 1'b1;
      else if (state_d == ST_ISSUE) done_show_q <= 1'b0;
    end
  end

  assign rep_state = (state_q == ST_IDLE && done_show_q) ? ST_DONE : state_q;
  assign cnt_sat   = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);

  // Status word assembly and read-data selection.
  always_comb begin
    stat = '0;
    stat[STAT_STATE_LSB +: 2]   = rep_state;
    stat[STAT_COUNT_LSB +: 4]   = cnt_sat;
    stat[STAT_OVF_BIT]          = ovf_q;
    stat[STAT_BAD_BIT]          = bad_q;
    stat[STAT_RESULT_LSB +: 16] = last_result_q;
    rd_data = '0;
    if (is_req)  rd_data[CMD_ID_W-1:0] = last_id_q;
    if (is_stat) rd_data = stat;
    for (int unsigned i = 0; i < NUM_PARAMS; i++)
      if (par_hit[i]) rd_data = params_q[i];
  end

  // Register file, sticky flags, result capture and fixed-latency read port.
  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      avl_readdata      <= '0;
      avl_readdatavalid <= 1'b0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) params_q[i] <= '0;
      last_id_q     <= '0;
      ovf_q         <= 1'b0;
      bad_q         <= 1'b0;
      last_result_q <= '0;
    end else begin
      avl_readdatavalid <= avl_read;
      avl_readdata      <= avl_read ? rd_data : '0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++)
        if (avl_write && par_hit[i]) params_q[i] <= avl_writedata;
      if (avl_write && is_stat) begin
        if (avl_writedata[STAT_OVF_BIT]) ovf_q <= 1'b0;
        if (avl_writedata[STAT_BAD_BIT]) bad_q <= 1'b0;
      end
      if (avl_write && is_req) begin
        if (!id_ok)                 bad_q <= 1'b1;
        else if (fifo_full && !pop) ovf_q <= 1'b1;
        else                        last_id_q <= wr_id;
      end
      if (state_q == ST_BUSY && rsp_valid) last_result_q <= rsp_result;
    end
  end

endmodule

// File: tb/tb_seq_debug_cmd_mailbox.sv
module tb_seq_debug_cmd_mailbox;

  localparam logic [19:0] BASE = 20'h15238;

  logic         clk = 1'b0;
  logic         avl_reset_n = 1'b0;
  logic [19:0]  avl_address = '0;
  logic         avl_read = 1'b0;
  logic         avl_write = 1'b0;
  logic [31:0]  avl_writedata = '0;
  logic [31:0]  avl_readdata;
  logic         avl_readdatavalid;
  logic         avl_waitrequest;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic [7:0]   cmd_id;
  logic [127:0] cmd_params;
  logic         rsp_valid = 1'b0;
  logic [15:0]  rsp_result = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_debug_cmd_mailbox #(
    .BASE_ADDR  ('h00015238),
    .NUM_PARAMS (4),
    .DEPTH      (4),
    .CMD_ID_W   (8),
    .CMD_ID_MAX ('h16),
    .ADDR_W     (20)
  ) dut (
    .avl_clk           (clk),
    .avl_reset_n       (avl_reset_n),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_waitrequest   (avl_waitrequest),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_id            (cmd_id),
    .cmd_params        (cmd_params),
    .rsp_valid         (rsp_valid),
    .rsp_result        (rsp_result)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected commands queued on accepted pushes, checked on handshake.
  typedef struct {
    logic [7:0]   id;
    logic [127:0] params;
  } cmd_t;

  cmd_t        sb[$];
  int          mdl_cnt = 0;
  int          n_pops  = 0;
  logic [31:0] shadow [4];

  always @(posedge clk) begin
    cmd_t        e;
    logic [19:0] a;
    if (!avl_reset_n) begin
      sb.delete();
      mdl_cnt = 0;
      for (int i = 0; i < 4; i++) shadow[i] = '0;
    end else begin
      a = avl_address - BASE;
      if (cmd_valid && cmd_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pop_id", cmd_id, e.id);
          check("pop_params", cmd_params, e.params);
          mdl_cnt--;
        end
      end
      if (avl_write && a == 20'h8 && avl_writedata[7:0] <= 8'h16 && mdl_cnt < 4) begin
        e.id     = avl_writedata[7:0];
        e.params = {shadow[3], shadow[2], shadow[1], shadow[0]};
        sb.push_back(e);
        mdl_cnt++;
      end
      if (avl_write && a >= 20'h10 && a < 20'h20 && a[1:0] == 2'b00)
        shadow[(a - 20'h10) >> 2] = avl_writedata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic avl_wr(input logic [19:0] ofs, input logic [31:0] d);
    avl_address   = BASE + ofs;
    avl_writedata = d;
    avl_write     = 1'b1;
    tick();
    avl_write = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [19:0] ofs, input logic [31:0] exp);
    avl_address = BASE + ofs;
    avl_read    = 1'b1;
    tick();
    avl_read = 1'b0;
    check({name, "_rdv"}, avl_readdatavalid, 1);
    check(name, avl_readdata, exp);
  endtask

  task automatic rsp_pulse(input logic [15:0] r);
    rsp_result = r;
    rsp_valid  = 1'b1;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, "_wait_valid"}, cmd_valid, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [19:0] ofs;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{1'b1, 20'h10, 32'h11111111, 32'h0};
    tbl[1]  = '{1'b1, 20'h14, 32'h22222222, 32'h0};
    tbl[2]  = '{1'b1, 20'h18, 32'h33333333, 32'h0};
    tbl[3]  = '{1'b1, 20'h1C, 32'h44444444, 32'h0};
    tbl[4]  = '{1'b0, 20'h10, 32'h0, 32'h11111111};
    tbl[5]  = '{1'b0, 20'h14, 32'h0, 32'h22222222};
    tbl[6]  = '{1'b0, 20'h18, 32'h0, 32'h33333333};
    tbl[7]  = '{1'b0, 20'h1C, 32'h0, 32'h44444444};
    tbl[8]  = '{1'b1, 20'h20, 32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{1'b0, 20'h20, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 20'h0,  32'h0, 32'h0};
    tbl[11] = '{1'b0, 20'h4,  32'h0, 32'h0};
    tbl[12] = '{1'b0, 20'h12, 32'h0, 32'h0};
    tbl[13] = '{1'b0, 20'h8,  32'h0, 32'h0};
    tbl[14] = '{1'b0, 20'hC,  32'h0, 32'h0};

    // Reset state
    repeat (2) tick();
    avl_reset_n = 1'b1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_id", cmd_id, 0);
    check("rst_cmd_params", cmd_params, 0);
    check("rst_rdv", avl_readdatavalid, 0);
    check("waitrequest", avl_waitrequest, 0);
    rd_check("rst_status", 20'hC, 32'h0);
    tick();
    check("rdv_drop", avl_readdatavalid, 0);

    // Register map vectors
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) avl_wr(tbl[i].ofs, tbl[i].wdata);
      else rd_check($sformatf("vec%0d", i), tbl[i].ofs, tbl[i].exp);
    end

    // Single command: 2-cycle latency, BUSY, result, DONE held into IDLE
    avl_wr(20'h10, 32'hDEAD);
    cmd_ready = 1'b1;
    avl_wr(20'h8, 32'h05);
    check("lat_cycle1_valid", cmd_valid, 0);
    tick();
    check("lat_cycle2_valid", cmd_valid, 1);
    check("lat_cmd_id", cmd_id, 8'h05);
    check("lat_param0", cmd_params[31:0], 32'hDEAD);
    tick();
    cmd_ready = 1'b0;
    rd_check("busy_status", 20'hC, 32'h0000_0002);
    rsp_pulse(16'h0001);
    rd_check("done_status", 20'hC, 32'h0001_0003);
    rd_check("done_held", 20'hC, 32'h0001_0003);
    rd_check("last_id5", 20'h8, 32'h5);

    // Overflow: five pushes into a depth-4 queue with the core stalled
    for (int i = 1; i <= 5; i++) avl_wr(20'h8, 32'(i));
    rd_check("ovf_status", 20'hC, 32'h0001_0141);
    check("stall_id_a", cmd_id, 8'h01);
    repeat (3) tick();
    check("stall_id_b", cmd_id, 8'h01);
    check("stall_valid", cmd_valid, 1);
    avl_wr(20'hC, 32'h100);
    rd_check("ovf_clear", 20'hC, 32'h0001_0041);

    // Illegal ID just above the maximum
    avl_wr(20'h8, 32'h17);
    rd_check("bad_status", 20'hC, 32'h0001_0241);
    rd_check("last_id4", 20'h8, 32'h4);
    avl_wr(20'hC, 32'hFFFF_02FF);
    rd_check("bad_clear", 20'hC, 32'h0001_0041);

    // Snapshot isolation, then push into a full queue while it pops
    avl_wr(20'h10, 32'h1234);
    cmd_ready = 1'b1;
    avl_wr(20'h8, 32'h06);
    cmd_ready = 1'b0;
    rd_check("full_pushpop", 20'hC, 32'h0001_0042);
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rsp_pulse(16'h0A00 + 16'(k));
      wait_valid($sformatf("drain%0d", k));
      tick();
    end
    rsp_pulse(16'h0A04);
    cmd_ready = 1'b0;
    check("drain_sb_empty", sb.size(), 0);
    rsp_pulse(16'hAAAA);
    rd_check("rsp_ignored_idle", 20'hC, 32'h0A04_0003);

    // Reset during BUSY with two commands still queued
    for (int i = 7; i <= 9; i++) avl_wr(20'h8, 32'(i));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    rd_check("busy_q2", 20'hC, 32'h0A04_0022);
    avl_reset_n = 1'b0;
    tick();
    check("midrst_valid", cmd_valid, 0);
    check("midrst_id", cmd_id, 0);
    avl_reset_n = 1'b1;
    rd_check("midrst_status", 20'hC, 32'h0);
    rsp_pulse(16'h5555);
    rd_check("midrst_rsp_ign", 20'hC, 32'h0);
    repeat (3) tick();
    check("midrst_no_issue", cmd_valid, 0);

    // Highest legal ID after reset: params snapshot back to zero
    cmd_ready = 1'b1;
    avl_wr(20'h8, 32'h16);
    wait_valid("maxid");
    tick();
    cmd_ready = 1'b0;
    rd_check("maxid_status", 20'hC, 32'h0000_0002);
    rd_check("maxid_last", 20'h8, 32'h16);
    check("final_sb_empty", sb.size(), 0);
    check("pop_count", n_pops, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_debug_cmd_mailbox.md
Name: seq_debug_cmd_mailbox

Overview:
Parametrised Avalon-MM debug command mailbox for the LPDDR2 sequencer core debug region. A host (Nios/JTAG master) writes parameters and a command ID. The command is snapshotted into a DEPTH-entry queue and handed to the sequencer core over a valid/ready handshake. The core returns a result, which is exposed in the status register. It succeeds the fixed single-slot REQ_CMD/CMD_STATUS/CMD_PARAMS map with configurable base, parameter count and queueing.

Parameters:
BASE_ADDR, 'h00015238, byte base of debug region; registers at BASE_ADDR+offset
NUM_PARAMS, 4, number of 32-bit parameter registers (1..8)
DEPTH, 4, command queue depth (power of 2, 2..16)
CMD_ID_W, 8, command ID width
CMD_ID_MAX, 'h16, highest legal command ID
ADDR_W, 20, Avalon byte-address width

Ports:
avl_clk  in  1  clock
avl_reset_n  in  1  synchronous active-low reset
avl_address  in  ADDR_W  byte address
avl_read  in  1  read strobe
avl_write  in  1  write strobe
avl_writedata  in  32  write data
avl_readdata  out  32  read data, valid one cycle after avl_read
avl_readdatavalid  out  1  read data qualifier
avl_waitrequest  out  1  tied 0
cmd_valid  out  1  queue head presented to core
cmd_ready  in  1  core accepts head
cmd_id  out  CMD_ID_W  head command ID
cmd_params  out  32*NUM_PARAMS  head parameter snapshot, param 0 in LSBs
rsp_valid  in  1  core completion pulse
rsp_result  in  16  completion code

Behaviour:
- One clock, avl_clk. Reset is synchronous, active-low (avl_reset_n); all state clears on the first sampled-low edge.
- Reset values: avl_readdata=0, avl_readdatavalid=0, cmd_valid=0, cmd_id=0, cmd_params=0, queue empty, all PARAMS=0, sticky bits=0, last_result=0, FSM=IDLE.
- Register map (byte offsets from BASE_ADDR):
  - 0x8 REQ_CMD. W: push {writedata[CMD_ID_W-1:0], PARAMS snapshot}. R: last accepted ID.
  - 0xC CMD_STATUS. R: [1:0] FSM state (0 IDLE, 1 ISSUE, 2 BUSY, 3 DONE); [7:4] queue count; [8] overflow sticky; [9] bad_cmd sticky; [31:16] last_result. W: 1 to bit 8/9 clears that bit. Writes to other bits are ignored.
  - 0x10+4*i PARAMS[i], i<NUM_PARAMS. R/W.
- Unmapped reads return 0 with readdatavalid. Unmapped writes are ignored. Read latency is fixed at 1.
- Push rules:
  - ID > CMD_ID_MAX: not enqueued; bad_cmd set.
  - Queue full: dropped; overflow set. Exception: a pop in the same cycle frees a slot, so the push is accepted.
  - Otherwise enqueued in the cycle after the write.
- Params are snapshotted at push, so later PARAMS writes do not affect queued commands.
- FSM:
  - IDLE: queue non-empty -> ISSUE.
  - ISSUE: cmd_valid=1 with head driven. cmd_valid && cmd_ready -> pop, go to BUSY.
  - BUSY: on rsp_valid, latch rsp_result into last_result, go to DONE.
  - DONE: lasts one cycle. Queue non-empty -> ISSUE, else IDLE. DONE remains the reported status until the next ISSUE.
- Minimum push-to-cmd_valid latency is 2 cycles (enqueue, then IDLE->ISSUE).
- cmd_id/cmd_params are stable while cmd_valid=1 and not ready.
- rsp_valid outside BUSY is ignored.
- Queue pointers wrap modulo DEPTH; count is DEPTH+1 states wide internally. The status field saturates at 15.
- Reset mid-operation: cmd_valid drops on the reset edge and queued commands are discarded. The core must tolerate an abandoned command.

Decomposition:
- Package seq_debug_mailbox_pkg:
  - register offset constants (REQ_CMD_OFS 'h8, CMD_STATUS_OFS 'hC, PARAMS_OFS 'h10)
  - state enum typedef
  - status bit-position constants
- Sub-module seq_debug_cmd_fifo: synchronous FIFO, width CMD_ID_W+32*NUM_PARAMS, depth DEPTH. Provides push/pop/full/empty/count and same-cycle push+pop when full.

Test Plan:
- Reset hold 2 cycles, then read CMD_STATUS at BASE+0xC -> readdata 0, readdatavalid 1 cycle after read.
- Write PARAMS0='hDEAD, then REQ_CMD='h05, cmd_ready=1 -> cmd_valid at cycle+2 with cmd_id 5 and cmd_params[31:0]='hDEAD. Status shows BUSY. rsp_valid with result 'h0001 -> status[31:16]=1, state DONE.
- Push 5 commands with DEPTH=4, cmd_ready=0 -> count 4, bit8 set. Write 'h100 to CMD_STATUS -> bit8 clears.
- Push ID 'h17 -> not queued, count unchanged, bit9 set.
- Queue full, cmd_ready=1 and REQ_CMD write in the same cycle -> push accepted, count stays 4, bit8 stays 0.
- Assert avl_reset_n=0 during BUSY with 2 queued -> next cycle cmd_valid=0, count 0, state IDLE. A subsequent rsp_valid is ignored.
